// File: rtl/gray_pkg.sv
// Shared types and constants for the bit-serial gray-to-binary controller.
// Holds the FSM encoding, the default word width and a reference conversion.
package gray_pkg;

  localparam int GRAY_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Whole-word reference conversion for benches; bits at and above w are zero.
  function automatic logic [31:0] gray2bin_ref(
    input logic [31:0] g,
    input int unsigned w
  );
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < w; i++) begin
      b = b ^ (g >> i);
    end
    if (w < 32) begin
      b = b & ((32'd1 << w) - 32'd1);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_xor_step.sv
// One step of gray-to-binary conversion: the next binary bit is the
// previous binary bit XORed with the current gray bit.
module gray_xor_step (
  input  logic prev_b_i,
  input  logic g_bit_i,
  output logic b_bit_o
);

  assign b_bit_o = prev_b_i ^ g_bit_i;

endmodule

// File: rtl/gray2bin_seq_ctrl.sv
// Bit-serial gray-to-binary controller, MSB first, one XOR step per cycle.
// Word in over valid/ready, result out over valid/ready, completed-word count.
module gray2bin_seq_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_bin,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [0:WIDTH-1]   g_q, g_d;
  logic [0:WIDTH-1]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   idx_m1;
  logic               prev_b;
  logic               step_b;

  // Previous binary bit feeding the shared step; MSB has no predecessor.
  always_comb begin
    idx_m1 = idx_q - ONE;
    prev_b = 1'b0;
    if (idx_q != '0) begin
      prev_b = bin_q[idx_m1];
    end
  end

  gray_xor_step u_step (
    .prev_b_i (prev_b),
    .g_bit_i  (g_q[0]),
    .b_bit_o  (step_b)
  );

  // State, index, shift register, result and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      g_q     <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      g_q     <= g_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    g_d       = g_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          g_d     = in_gray;
          idx_d   = '0;
          bin_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        busy         = 1'b1;
        bin_d[idx_q] = step_b;
        g_d          = {g_q[1:WIDTH-1], 1'b0};
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_bin  = bin_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_gray2bin_seq_ctrl.sv
// Bench for gray2bin_seq_ctrl: directed scenarios then random traffic,
// checked every cycle against a transaction-level model.
module tb_gray2bin_seq_ctrl;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [0:W-1] in_gray;

  logic         in_ready, out_valid, busy;
  logic [0:W-1] out_bin;
  logic [7:0]   word_cnt;

  logic         in_ready2, out_valid2, busy2;
  logic [0:W-1] out_bin2;
  logic [1:0]   word_cnt2;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  bit m_valid;
  int m_wait;
  int m_word;
  int m_res;
  int m_cnt;

  always #5 clk = ~clk;

  gray2bin_seq_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  gray2bin_seq_ctrl #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_gray   (in_gray),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_bin   (out_bin2),
    .busy      (busy2),
    .word_cnt  (word_cnt2)
  );

  function automatic int g2b(input int g);
    int b;
    int s;
    b = g;
    s = g >> 1;
    while (s != 0) begin
      b = b ^ s;
      s = s >> 1;
    end
    return b;
  endfunction

  function automatic bit m_idle();
    return (m_wait == 0) && !m_valid;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_valid = 1'b0;
      m_wait  = 0;
      m_cnt   = 0;
    end else if (m_idle()) begin
      if (in_valid) begin
        m_wait = W;
        m_word = int'(in_gray);
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_res   = g2b(m_word);
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_cnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    chk("in_ready", 32'(in_ready), 32'(m_idle()));
    chk("busy", 32'(busy), 32'(!m_idle()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_valid2", 32'(out_valid2), 32'(m_valid));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt % 256));
    chk("word_cnt2", 32'(word_cnt2), 32'(m_cnt % 4));
    if (m_valid) begin
      chk("out_bin", 32'(out_bin), 32'(m_res));
      chk("out_bin2", 32'(out_bin2), 32'(m_res));
    end
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      cyc();
      t++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int hs;
    int k;
    int t;
    int done_n;
    int last;
    bit take;
    bit cons;
    int exp_seq [5];

    exp_seq = '{1, 2, 3, 0, 1};
    m_valid = 1'b0;
    m_wait  = 0;
    m_word  = 0;
    m_res   = 0;
    m_cnt   = 0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_gray   = '0;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single word, latency and value
    in_gray  = 3'b110;
    in_valid = 1'b1;
    hs = cyc_n;
    cyc();
    in_valid = 1'b0;
    wait_valid("t1_wait");
    chk("t1_lat", 32'(cyc_n - hs), 32'd4);
    chk("t1_bin", 32'(out_bin), 32'b100);
    cyc();
    chk("t1_cnt", 32'(word_cnt), 32'd1);

    // Back-to-back sweep of every code
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    k = 0;
    done_n = 0;
    last = -1;
    t = 0;
    in_gray  = '0;
    in_valid = 1'b1;
    while (done_n < 8 && t < 100) begin
      take = m_idle() && in_valid;
      cons = m_valid && out_ready;
      cyc();
      t++;
      if (take) begin
        k++;
        if (k == 8) in_valid = 1'b0;
        else in_gray = 3'(k);
      end
      if (cons) begin
        if (last >= 0) chk("t2_period", 32'(cyc_n - last), 32'd5);
        last = cyc_n;
        done_n++;
      end
    end
    in_valid = 1'b0;
    chk("t2_done", 32'(done_n), 32'd8);
    chk("t2_cnt", 32'(word_cnt), 32'd8);

    // Output back-pressure
    in_gray   = 3'b111;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    wait_valid("t3_wait");
    for (int i = 0; i < 6; i++) begin
      chk("t3_bin", 32'(out_bin), 32'b101);
      chk("t3_rdy", 32'(in_ready), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    chk("t3_idle", 32'(in_ready), 32'd1);

    // Input change during conversion is ignored
    in_gray  = 3'b011;
    in_valid = 1'b1;
    cyc();
    in_gray = 3'b100;
    cyc();
    in_valid = 1'b0;
    in_gray  = '0;
    wait_valid("t4_wait");
    chk("t4_bin", 32'(out_bin), 32'b010);
    cyc();

    // Reset in the second conversion cycle
    in_gray  = 3'b101;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_bin", 32'(out_bin), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rdy", 32'(in_ready), 32'd1);
    chk("t5_cnt", 32'(word_cnt), 32'd0);

    // Narrow counter wraps
    for (int w = 0; w < 5; w++) begin
      in_gray  = 3'($urandom);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      wait_valid("t6_wait");
      cyc();
      chk("t6_cnt2", 32'(word_cnt2), 32'(exp_seq[w]));
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_gray   = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
